bsg_manycore_eva_to_npa_pipe: RTL and testbench
===============================================

BSG_MANYCORE_EVA_TO_NPA_PIPE -- requirements
Module: bsg_manycore_eva_to_npa_pipe

Interface
REQ-001 Parameters (name, default, meaning):
 - data_width_p, 32, EVA width.
 - addr_width_p, 28, EPA word-address width.
 - x_cord_width_p, 4, x-coordinate width.
 - y_cord_width_p, 4, y-coordinate width.
 - num_tiles_x_p, 4, tile columns; power of 2.
 - num_tiles_y_p, 4, tile rows.
 - num_vcache_rows_p, 2, vcache rows: 1 = top only, 2 = top and bottom.
 - vcache_block_size_in_words_p, 8, words per vcache line; power of 2.
 - vcache_size_p, 1024, words per vcache; power of 2.
 - err_count_width_p, 8, invalid-counter width.
REQ-002 Ports (name, direction, width, meaning):
 - clk_i, in, 1, clock.
 - reset_i, in, 1, reset; synchronous, active-high.
 - v_i, in, 1, request valid.
 - ready_o, out, 1, request accepted when v_i & ready_o.
 - eva_i, in, data_width_p, byte EVA.
 - tgo_x_i, in, x_cord_width_p, tile-group origin x.
 - tgo_y_i, in, y_cord_width_p, tile-group origin y.
 - tg_dim_x_i, in, x_cord_width_p, tile-group x dimension.
 - tg_dim_y_i, in, y_cord_width_p, tile-group y dimension.
 - dram_enable_i, in, 1, striped DRAM mode.
 - v_o, out, 1, result valid.
 - yumi_i, in, 1, consumer takes result; legal only when v_o=1.
 - x_cord_o, out, x_cord_width_p, destination x.
 - y_cord_o, out, y_cord_width_p, destination y.
 - epa_o, out, addr_width_p, endpoint word address.
 - is_invalid_addr_o, out, 1, EVA has no remote NPA.
 - err_v_o, out, 1, sticky error flag.
 - err_eva_o, out, data_width_p, first invalid EVA.
 - err_count_o, out, err_count_width_p, count of invalid EVAs accepted.
 - err_clr_i, in, 1, clears error state.

Function
REQ-003 Definitions:
 - banks = num_tiles_x_p*num_vcache_rows_p; lgb = log2(banks).
 - wo = log2(vcache_block_size_in_words_p); lgs = log2(vcache_size_p).
 - w = eva_i[31:2].
REQ-004 Single-entry output register; 1-cycle latency: a request accepted in cycle N produces v_o=1 in cycle N+1.
REQ-005 ready_o = ~v_o | yumi_i; simultaneous yumi_i and accept replaces the entry with no bubble.
REQ-006 While v_o=1 and yumi_i=0, all result outputs hold stable.
REQ-007 Translation uses tgo/tg_dim/dram_enable values sampled in the accept cycle.
REQ-008 DRAM class (eva_i[31]=1), dram_enable_i=1, striped:
 - bank = w[wo +: lgb].
 - x = bank mod num_tiles_x_p; row = bank / num_tiles_x_p.
 - y = 0 for row 0; y = num_tiles_y_p+1 for row 1.
 - epa = {w >> (wo+lgb), w[wo-1:0]}, zero-extended.
REQ-009 DRAM class, dram_enable_i=0, eva_i[30]=1 (host): x=0, y=1, epa={1'b1, w[addr_width_p-2:0]}.
REQ-010 DRAM class, dram_enable_i=0, eva_i[30]=0 (block mode):
 - bank = w[lgs +: lgb]; x and y derived from bank as in REQ-008.
 - epa = w[lgs-1:0], zero-extended.
REQ-011 Global class (eva_i[31:30]=01): y=eva_i[29:24], x=eva_i[23:18], epa=eva_i[17:2]; coordinates truncated to port width.
REQ-012 Tile-group class (eva_i[31:29]=001):
 - offsets yo=eva_i[28:23], xo=eva_i[22:17]; epa=eva_i[16:2].
 - x = xo+tgo_x_i, y = yo+tgo_y_i, each modulo 2^width.
 - Invalid if xo>=tg_dim_x_i or yo>=tg_dim_y_i.
REQ-013 Any other EVA is invalid. An invalid result reports x=0, y=0, epa=0 with is_invalid_addr_o=1.
REQ-014 Invalid results still complete the handshake; none are dropped.

Reset
REQ-015 While reset_i is high at a clock edge: v_o, x/y/epa, is_invalid_addr_o, err_v_o, err_eva_o and err_count_o all become 0; ready_o=1 the cycle after.
REQ-016 Reset mid-operation discards any held result without emitting it.

Configuration
REQ-017 Macro BSG_MANYCORE_EVA_TO_NPA_ERR_CAPTURE_EN defined:
 - Accepting an invalid EVA sets err_v_o and increments err_count_o, which saturates at all-ones.
 - err_eva_o latches the EVA only while err_v_o=0.
 - err_clr_i zeroes all three; if err_clr_i coincides with an invalid accept, the new EVA is captured and the count becomes 1.
REQ-018 Macro not defined: err_v_o, err_eva_o and err_count_o are tied 0; err_clr_i is ignored.

Verification (default parameters; macro defined)
REQ-019 dram_enable_i=1, eva 0x8000_0124 -> x=1, y=0, epa=9; eva 0x8000_0124|(4<<5) (bank 5) -> x=1, y=5, epa=9.
REQ-020 dram_enable_i=0, eva 0x8000_1008 -> x=1, y=0, epa=2; eva 0xC000_0010 -> x=0, y=1, epa=0x800_0004.
REQ-021 Global 0x4308_0400 -> x=2, y=3, epa=0x100. Tile-group with tgo=(2,1), dim=(2,2): eva 0x2082_0040 -> x=3, y=2, epa=0x10; eva 0x2004_0040 -> invalid.
REQ-022 Backpressure: hold yumi_i=0 for 5 cycles with v_i=1 -> ready_o=0, outputs stable; then yumi_i=1 -> next request accepted the same cycle.
REQ-023 Errors: invalid 0x0000_1000 then 0x0000_2000 -> err_eva_o=0x1000, err_count_o=2; err_clr_i together with invalid 0x3000 -> err_eva_o=0x3000, count=1; 300 invalids -> count=255.

Source files
------------

// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// bsg_manycore_eva_to_npa_pipe: translates a byte EVA into a network physical
// address (x, y, endpoint word address) through a single-entry output register.
// Optional error capture is enabled with BSG_MANYCORE_EVA_TO_NPA_ERR_CAPTURE_EN.
// Bit positions of the EVA classes assume data_width_p = 32.
module bsg_manycore_eva_to_npa_pipe #(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 4,
  parameter int y_cord_width_p               = 4,
  parameter int num_tiles_x_p                = 4,
  parameter int num_tiles_y_p                = 4,
  parameter int num_vcache_rows_p            = 2,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_size_p                = 1024,
  parameter int err_count_width_p            = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [data_width_p-1:0]      eva_i,
  input  logic [x_cord_width_p-1:0]    tgo_x_i,
  input  logic [y_cord_width_p-1:0]    tgo_y_i,
  input  logic [x_cord_width_p-1:0]    tg_dim_x_i,
  input  logic [y_cord_width_p-1:0]    tg_dim_y_i,
  input  logic                         dram_enable_i,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [x_cord_width_p-1:0]    x_cord_o,
  output logic [y_cord_width_p-1:0]    y_cord_o,
  output logic [addr_width_p-1:0]      epa_o,
  output logic                         is_invalid_addr_o,
  output logic                         err_v_o,
  output logic [data_width_p-1:0]      err_eva_o,
  output logic [err_count_width_p-1:0] err_count_o,
  input  logic                         err_clr_i
);

  localparam int BANKS = num_tiles_x_p * num_vcache_rows_p;
  localparam int LGB   = $clog2(BANKS);
  localparam int WO    = $clog2(vcache_block_size_in_words_p);
  localparam int LGS   = $clog2(vcache_size_p);
  localparam logic [data_width_p-1:0] WO_MASK  = (data_width_p'(1) << WO) - data_width_p'(1);
  localparam logic [data_width_p-1:0] LGS_MASK = (data_width_p'(1) << LGS) - data_width_p'(1);

  logic                      r_v;
  logic [x_cord_width_p-1:0] r_x;
  logic [y_cord_width_p-1:0] r_y;
  logic [addr_width_p-1:0]   r_epa;
  logic                      r_inv;

  logic                      w_accept;
  logic [data_width_p-1:0]   w_wd;
  logic [addr_width_p-1:0]   w_str_epa;
  logic [addr_width_p-1:0]   w_blk_epa;
  logic [5:0]                w_xo, w_yo;
  logic [LGB-1:0]            w_bank;
  logic [x_cord_width_p-1:0] w_x;
  logic [y_cord_width_p-1:0] w_y;
  logic [addr_width_p-1:0]   w_epa;
  logic                      w_inv;

  assign ready_o  = ~r_v | yumi_i;
  assign w_accept = v_i & ready_o;

  // DRAM word address without the class bit; the striped address squeezes
  // the bank-select field out from between line offset and line index.
  assign w_wd      = {3'b000, eva_i[data_width_p-2:2]};
  assign w_str_epa = addr_width_p'(((w_wd >> (WO + LGB)) << WO) | (w_wd & WO_MASK));
  assign w_blk_epa = addr_width_p'(w_wd & LGS_MASK);
  assign w_xo      = eva_i[22:17];
  assign w_yo      = eva_i[28:23];

  // EVA class decode and translation of the request being offered
  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_epa  = '0;
    w_inv  = 1'b0;
    w_bank = '0;
    if (eva_i[31]) begin
      if (~dram_enable_i & eva_i[30]) begin
        // host space
        w_y   = y_cord_width_p'(1);
        w_epa = {1'b1, eva_i[addr_width_p:2]};
      end else begin
        if (dram_enable_i) begin
          w_bank = eva_i[2+WO +: LGB];
          w_epa  = w_str_epa;
        end else begin
          w_bank = eva_i[2+LGS +: LGB];
          w_epa  = w_blk_epa;
        end
        w_x = x_cord_width_p'(32'(w_bank) % num_tiles_x_p);
        // bottom vcache row sits just below the last tile row
        if ((32'(w_bank) / num_tiles_x_p) != 32'd0)
          w_y = y_cord_width_p'(num_tiles_y_p + 1);
      end
    end else if (eva_i[30]) begin
      w_y   = y_cord_width_p'(eva_i[29:24]);
      w_x   = x_cord_width_p'(eva_i[23:18]);
      w_epa = addr_width_p'(eva_i[17:2]);
    end else if (eva_i[29]) begin
      if ((32'(w_xo) >= 32'(tg_dim_x_i)) || (32'(w_yo) >= 32'(tg_dim_y_i))) begin
        w_inv = 1'b1;
      end else begin
        w_x   = x_cord_width_p'(w_xo) + tgo_x_i;
        w_y   = y_cord_width_p'(w_yo) + tgo_y_i;
        w_epa = addr_width_p'(eva_i[16:2]);
      end
    end else begin
      w_inv = 1'b1;
    end
  end

  // output register: load on accept, drop valid when consumed without refill
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v   <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_epa <= '0;
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_v   <= 1'b1;
      r_x   <= w_x;
      r_y   <= w_y;
      r_epa <= w_epa;
      r_inv <= w_inv;
    end else if (yumi_i) begin
      r_v   <= 1'b0;
    end
  end

  assign v_o               = r_v;
  assign x_cord_o          = r_x;
  assign y_cord_o          = r_y;
  assign epa_o             = r_epa;
  assign is_invalid_addr_o = r_inv;

`ifdef BSG_MANYCORE_EVA_TO_NPA_ERR_CAPTURE_EN
  logic                         r_err_v;
  logic [data_width_p-1:0]      r_err_eva;
  logic [err_count_width_p-1:0] r_err_cnt;
  logic                         w_err_acc;

  assign w_err_acc = w_accept & w_inv;

  // sticky error capture: first bad EVA, saturating count; clear wins but
  // a coincident bad accept starts the new record
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err_v   <= 1'b0;
      r_err_eva <= '0;
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_v   <= w_err_acc;
      r_err_eva <= w_err_acc ? eva_i : '0;
      r_err_cnt <= w_err_acc ? err_count_width_p'(1) : '0;
    end else if (w_err_acc) begin
      r_err_v <= 1'b1;
      if (~r_err_v)
        r_err_eva <= eva_i;
      if (r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + err_count_width_p'(1);
    end
  end

  assign err_v_o     = r_err_v;
  assign err_eva_o   = r_err_eva;
  assign err_count_o = r_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr_i;
  assign err_v_o     = 1'b0;
  assign err_eva_o   = '0;
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_eva_to_npa_pipe.sv
// Bench for bsg_manycore_eva_to_npa_pipe: directed vectors plus random traffic
// against an arithmetic reference model and handshake scoreboard.
module tb_bsg_manycore_eva_to_npa_pipe;

`ifdef BSG_MANYCORE_EVA_TO_NPA_ERR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i, v_i, yumi_i, dram_en, err_clr;
  logic [31:0] eva;
  logic [3:0]  tgo_x, tgo_y, dim_x, dim_y;
  logic        ready_o, v_o, inv_o, err_v_o;
  logic [3:0]  x_o, y_o;
  logic [27:0] epa_o;
  logic [31:0] err_eva_o;
  logic [7:0]  err_cnt_o;

  int checks = 0;
  int failures = 0;

  // scoreboard state
  logic        m_v, m_inv, m_ev;
  logic [3:0]  m_x, m_y;
  logic [27:0] m_epa;
  logic [31:0] m_eeva;
  int          m_ecnt;

  always #5 clk = ~clk;

  bsg_manycore_eva_to_npa_pipe dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .eva_i(eva),
    .tgo_x_i(tgo_x), .tgo_y_i(tgo_y), .tg_dim_x_i(dim_x), .tg_dim_y_i(dim_y),
    .dram_enable_i(dram_en), .v_o(v_o), .yumi_i(yumi_i), .x_cord_o(x_o),
    .y_cord_o(y_o), .epa_o(epa_o), .is_invalid_addr_o(inv_o), .err_v_o(err_v_o),
    .err_eva_o(err_eva_o), .err_count_o(err_cnt_o), .err_clr_i(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference translation for the default parameter set
  function automatic void ref_xlate(input logic [31:0] e, input logic [3:0] tx, ty, dx, dy,
                                    input logic de, output logic [3:0] x, y,
                                    output logic [27:0] epa, output logic inv);
    int unsigned w, bank, xo, yo;
    w = e >> 2;
    x = 0; y = 0; epa = 0; inv = 0;
    if (e[31]) begin
      if (!de && e[30]) begin
        y   = 4'd1;
        epa = 28'((1 << 27) + (w % (1 << 27)));
      end else begin
        if (de) begin
          bank = (w / 8) % 8;
          epa  = 28'(((w % (1 << 29)) / 64) * 8 + (w % 8));
        end else begin
          bank = (w / 1024) % 8;
          epa  = 28'(w % 1024);
        end
        x = 4'(bank % 4);
        y = (bank / 4 == 1) ? 4'd5 : 4'd0;
      end
    end else if (e[30]) begin
      y   = 4'((e >> 24) % 64);
      x   = 4'((e >> 18) % 64);
      epa = 28'((e >> 2) % 65536);
    end else if (e[29]) begin
      yo = (e >> 23) % 64;
      xo = (e >> 17) % 64;
      if (xo >= 32'(dx) || yo >= 32'(dy)) inv = 1;
      else begin
        x   = 4'((xo + 32'(tx)) % 16);
        y   = 4'((yo + 32'(ty)) % 16);
        epa = 28'((e >> 2) % 32768);
      end
    end else begin
      inv = 1;
    end
  endfunction

  // One clock: drive inputs, check ready, advance the model, check outputs
  task automatic step(input logic rst, input logic v, input logic [31:0] e,
                      input logic y, input logic clr);
    logic acc, ninv;
    logic [3:0] nx, ny;
    logic [27:0] ne;
    reset_i = rst; v_i = v; eva = e; yumi_i = y & m_v; err_clr = clr;
    #1;
    if (!rst) chk("ready", 64'(ready_o), 64'(!m_v || yumi_i));
    acc = v && (!m_v || yumi_i) && !rst;
    ref_xlate(e, tgo_x, tgo_y, dim_x, dim_y, dram_en, nx, ny, ne, ninv);
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_x = 0; m_y = 0; m_epa = 0; m_inv = 0;
      m_ev = 0; m_eeva = 0; m_ecnt = 0;
    end else begin
      if (acc) begin
        m_v = 1; m_x = nx; m_y = ny; m_epa = ne; m_inv = ninv;
      end else if (yumi_i) m_v = 0;
      if (clr) begin
        m_ev   = acc && ninv;
        m_eeva = (acc && ninv) ? e : 32'h0;
        m_ecnt = (acc && ninv) ? 1 : 0;
      end else if (acc && ninv) begin
        if (!m_ev) m_eeva = e;
        m_ev = 1;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
    #1;
    chk("v_o", 64'(v_o), 64'(m_v));
    chk("x", 64'(x_o), 64'(m_x));
    chk("y", 64'(y_o), 64'(m_y));
    chk("epa", 64'(epa_o), 64'(m_epa));
    chk("inv", 64'(inv_o), 64'(m_inv));
    chk("err_v", 64'(err_v_o), ERR_EN ? 64'(m_ev) : 64'd0);
    chk("err_eva", 64'(err_eva_o), ERR_EN ? 64'(m_eeva) : 64'd0);
    chk("err_cnt", 64'(err_cnt_o), ERR_EN ? 64'(m_ecnt) : 64'd0);
  endtask

  initial begin
    m_v = 0; m_x = 0; m_y = 0; m_epa = 0; m_inv = 0; m_ev = 0; m_eeva = 0; m_ecnt = 0;
    reset_i = 1; v_i = 0; yumi_i = 0; dram_en = 1; err_clr = 0; eva = 0;
    tgo_x = 0; tgo_y = 0; dim_x = 0; dim_y = 0;

    // reset state
    step(1, 0, 32'h0, 0, 0);
    step(1, 1, 32'h8000_0124, 0, 0);
    step(0, 0, 32'h0, 0, 0);

    // striped DRAM, then back-to-back replace with yumi
    dram_en = 1;
    step(0, 1, 32'h8000_0124, 0, 0);
    chk("r19a_x", 64'(x_o), 64'd1); chk("r19a_y", 64'(y_o), 64'd0); chk("r19a_epa", 64'(epa_o), 64'd9);
    step(0, 1, 32'h8000_01A4, 1, 0);
    chk("r19b_x", 64'(x_o), 64'd1); chk("r19b_y", 64'(y_o), 64'd5); chk("r19b_epa", 64'(epa_o), 64'd9);

    // block mode and host
    dram_en = 0;
    step(0, 1, 32'h8000_1008, 1, 0);
    chk("r20a_x", 64'(x_o), 64'd1); chk("r20a_y", 64'(y_o), 64'd0); chk("r20a_epa", 64'(epa_o), 64'd2);
    step(0, 1, 32'hC000_0010, 1, 0);
    chk("r20b_x", 64'(x_o), 64'd0); chk("r20b_y", 64'(y_o), 64'd1); chk("r20b_epa", 64'(epa_o), 64'h800_0004);

    // global and tile-group
    tgo_x = 2; tgo_y = 1; dim_x = 2; dim_y = 2;
    step(0, 1, 32'h4308_0400, 1, 0);
    chk("r21g_x", 64'(x_o), 64'd2); chk("r21g_y", 64'(y_o), 64'd3); chk("r21g_epa", 64'(epa_o), 64'h100);
    step(0, 1, 32'h2082_0040, 1, 0);
    chk("r21t_x", 64'(x_o), 64'd3); chk("r21t_y", 64'(y_o), 64'd2); chk("r21t_epa", 64'(epa_o), 64'h10);
    step(0, 1, 32'h2004_0040, 1, 0);
    chk("r21i_inv", 64'(inv_o), 64'd1); chk("r21i_epa", 64'(epa_o), 64'd0);

    // backpressure: five stalled cycles, then consume and refill together
    step(0, 1, 32'h4308_0400, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'h8000_1008, 0, 0);
      chk("bp_ready", 64'(ready_o), 64'd0);
      chk("bp_x", 64'(x_o), 64'd2);
      chk("bp_epa", 64'(epa_o), 64'h100);
    end
    step(0, 1, 32'h8000_1008, 1, 0);
    chk("bp_new_x", 64'(x_o), 64'd1); chk("bp_new_epa", 64'(epa_o), 64'd2);

    // error capture
    step(0, 0, 32'h0, 1, 1);
    step(0, 1, 32'h0000_1000, 1, 0);
    step(0, 1, 32'h0000_2000, 1, 0);
    chk("r23_eva", 64'(err_eva_o), ERR_EN ? 64'h1000 : 64'd0);
    chk("r23_cnt", 64'(err_cnt_o), ERR_EN ? 64'd2 : 64'd0);
    step(0, 1, 32'h0000_3000, 1, 1);
    chk("r23_clr_eva", 64'(err_eva_o), ERR_EN ? 64'h3000 : 64'd0);
    chk("r23_clr_cnt", 64'(err_cnt_o), ERR_EN ? 64'd1 : 64'd0);
    for (int i = 0; i < 300; i++) step(0, 1, 32'h0000_0100 + 32'(i), 1, 0);
    chk("r23_sat", 64'(err_cnt_o), ERR_EN ? 64'd255 : 64'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] e;
      case ($urandom % 5)
        0: e = {1'b1, 31'($urandom)};
        1: e = {2'b01, 30'($urandom)};
        2: e = {3'b001, 6'($urandom % 5), 6'($urandom % 5), 17'($urandom)};
        3: e = {3'b000, 29'($urandom)};
        default: e = $urandom;
      endcase
      tgo_x = 4'($urandom); tgo_y = 4'($urandom);
      dim_x = 4'($urandom % 6); dim_y = 4'($urandom % 6);
      dram_en = 1'($urandom);
      step(0, ($urandom % 4) != 0, e, 1'($urandom), ($urandom % 50) == 0);
    end

    // reset discards a held result
    step(0, 1, 32'h4308_0400, 0, 0);
    step(0, 1, 32'h8000_0124, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    chk("rst_v", 64'(v_o), 64'd0);
    step(0, 0, 32'h0, 0, 0);
    chk("rst_ready", 64'(ready_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
